// File: rtl/timer_periph.sv
// Memory-mapped 32-bit timer/compare peripheral with gnt/rvalid bus handshake.
// Define TIMER_PRESCALER_EN to build the 8-bit prescaler (CTRL.PRESC).
module timer_periph #(
  parameter int          ADDR_W      = 4,
  parameter logic [31:0] RST_COMPARE = 32'hFFFF_FFFF
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              en_i,
  input  logic              data_req_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  output logic [31:0]       data_rdata_o,
  input  logic              data_we_i,
  input  logic [3:0]        data_be_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [31:0]       data_wdata_i,
  output logic              timer_irq_o
);

  localparam logic [ADDR_W-3:0] IDX_CTRL    = (ADDR_W-2)'(0);
  localparam logic [ADDR_W-3:0] IDX_COUNT   = (ADDR_W-2)'(1);
  localparam logic [ADDR_W-3:0] IDX_COMPARE = (ADDR_W-2)'(2);
  localparam logic [ADDR_W-3:0] IDX_STATUS  = (ADDR_W-2)'(3);

  logic              req_ok, wr, rd;
  logic [ADDR_W-3:0] widx;
  logic              wr_ctrl, wr_count, wr_compare, wr_status;
  logic              en_q, autoreload_q, irq_en_q, match_q;
  logic [31:0]       count_q, compare_q;
  logic              tick, match_hit;
  logic [7:0]        presc_rd;
  logic [31:0]       read_val;
  logic              rvalid_q;
  logic [31:0]       rdata_q;
  logic              addr_unused;

  assign req_ok     = data_req_i & en_i;
  assign data_gnt_o = req_ok;
  assign wr         = req_ok & data_we_i;
  assign rd         = req_ok & ~data_we_i;
  assign widx       = data_addr_i[ADDR_W-1:2];
  assign addr_unused = ^data_addr_i[1:0];

  assign wr_ctrl    = wr && (widx == IDX_CTRL);
  assign wr_count   = wr && (widx == IDX_COUNT);
  assign wr_compare = wr && (widx == IDX_COMPARE);
  assign wr_status  = wr && (widx == IDX_STATUS);

  function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

`ifdef TIMER_PRESCALER_EN
  logic [7:0] presc_q, pcnt_q;

  assign tick     = en_q && (pcnt_q == presc_q);
  assign presc_rd = presc_q;

  // A PRESC write restarts the prescale period from zero.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      presc_q <= 8'h00;
      pcnt_q  <= 8'h00;
    end else begin
      if (wr_ctrl && data_be_i[1]) begin
        presc_q <= data_wdata_i[15:8];
        pcnt_q  <= 8'h00;
      end else if (en_q) begin
        pcnt_q  <= tick ? 8'h00 : pcnt_q + 8'd1;
      end
    end
  end
`else
  assign tick     = en_q;
  assign presc_rd = 8'h00;
`endif

  // Match is judged on the pre-write COUNT even when software overwrites it.
  assign match_hit = tick && (count_q == compare_q);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      en_q         <= 1'b0;
      autoreload_q <= 1'b0;
      irq_en_q     <= 1'b0;
      count_q      <= 32'h0;
      compare_q    <= RST_COMPARE;
      match_q      <= 1'b0;
    end else begin
      if (wr_ctrl && data_be_i[0]) begin
        en_q         <= data_wdata_i[0];
        autoreload_q <= data_wdata_i[1];
        irq_en_q     <= data_wdata_i[2];
      end
      if (wr_count)
        count_q <= merge_be(count_q, data_wdata_i, data_be_i);
      else if (tick)
        count_q <= (match_hit && autoreload_q) ? 32'h0 : count_q + 32'd1;
      if (wr_compare)
        compare_q <= merge_be(compare_q, data_wdata_i, data_be_i);
      // Set wins over a simultaneous write-1-to-clear.
      if (match_hit)
        match_q <= 1'b1;
      else if (wr_status && data_be_i[0] && data_wdata_i[0])
        match_q <= 1'b0;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    read_val = 32'h0;
    case (widx)
      IDX_CTRL:    read_val = {16'h0, presc_rd, 5'b0, irq_en_q, autoreload_q, en_q};
      IDX_COUNT:   read_val = count_q;
      IDX_COMPARE: read_val = compare_q;
      IDX_STATUS:  read_val = {31'h0, match_q};
      default:     read_val = 32'h0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
    end else begin
      rvalid_q <= req_ok;
      rdata_q  <= rd ? read_val : 32'h0;
    end
  end

  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign timer_irq_o   = match_q & irq_en_q;

endmodule

// File: tb/tb_timer_periph.sv
// Directed self-checking bench for timer_periph; honours TIMER_PRESCALER_EN.
module tb_timer_periph;

  localparam logic [3:0] A_CTRL = 4'h0, A_COUNT = 4'h4, A_COMPARE = 4'h8, A_STATUS = 4'hC;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic        req = 1'b0;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        we = 1'b0;
  logic [3:0]  be = 4'h0;
  logic [3:0]  addr = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic        irq;

  int checks = 0;
  int errors = 0;

  timer_periph #(.ADDR_W(4), .RST_COMPARE(32'hFFFF_FFFF)) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .en_i         (en),
    .data_req_i   (req),
    .data_gnt_o   (gnt),
    .data_rvalid_o(rvalid),
    .data_rdata_o (rdata),
    .data_we_i    (we),
    .data_be_i    (be),
    .data_addr_i  (addr),
    .data_wdata_i (wdata),
    .timer_irq_o  (irq)
  );

  always #5 clk = ~clk;

  // Entered and left on a falling edge; one bus transfer per call.
  task automatic xfer(input logic w, input logic [3:0] a, input logic [31:0] d,
                      input logic [3:0] b, output logic [31:0] r);
    req = 1'b1; en = 1'b1; we = w; addr = a; wdata = d; be = b;
    #1;
    checks++;
    if (gnt !== 1'b1) begin
      errors++; $display("FAIL gnt addr=%h: got %b expected 1", a, gnt);
    end
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; en = 1'b0; we = 1'b0;
    checks++;
    if (rvalid !== 1'b1) begin
      errors++; $display("FAIL rvalid addr=%h: got %b expected 1", a, rvalid);
    end
    r = rdata;
    if (w) begin
      checks++;
      if (rdata !== 32'h0) begin
        errors++; $display("FAIL write_rdata addr=%h: got %h expected 0", a, rdata);
      end
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    logic [31:0] dummy;
    xfer(1'b1, a, d, b, dummy);
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] r);
    xfer(1'b0, a, 32'h0, 4'h0, r);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset;
    logic [31:0] r;
    logic [31:0] exp_tab [4] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0};
    logic [3:0]  adr_tab [4] = '{A_CTRL, A_COUNT, A_COMPARE, A_STATUS};
    do_reset();
    checks++;
    if (rvalid !== 1'b0 || rdata !== 32'h0 || irq !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: got rvalid=%b rdata=%h irq=%b expected 0/0/0", rvalid, rdata, irq);
    end
    for (int i = 0; i < 4; i++) begin
      rd(adr_tab[i], r);
      checks++;
      if (r !== exp_tab[i]) begin
        errors++; $display("FAIL reset_reg addr=%h: got %h expected %h", adr_tab[i], r, exp_tab[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (rvalid !== 1'b0 || rdata !== 32'h0) begin
      errors++; $display("FAIL idle_response: got rvalid=%b rdata=%h expected 0/0", rvalid, rdata);
    end
    // Request without peripheral select: no grant, no response, no write.
    req = 1'b1; en = 1'b0; we = 1'b1; addr = A_COMPARE; wdata = 32'h1234; be = 4'hF;
    #1;
    checks++;
    if (gnt !== 1'b0) begin
      errors++; $display("FAIL gnt_unselected: got %b expected 0", gnt);
    end
    @(negedge clk);
    req = 1'b0; we = 1'b0;
    checks++;
    if (rvalid !== 1'b0) begin
      errors++; $display("FAIL rvalid_unselected: got %b expected 0", rvalid);
    end
    rd(A_COMPARE, r);
    checks++;
    if (r !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL unselected_write_ignored: got %h expected ffffffff", r);
    end
  endtask

  task automatic test_autoreload;
    logic [31:0] r;
    do_reset();
    wr(A_COMPARE, 32'd5, 4'hF);
    wr(A_CTRL, 32'h7, 4'hF);
    repeat (5) @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_before_match: got %b expected 0", irq);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL irq_first_match: got %b expected 1", irq);
    end
    wr(A_STATUS, 32'h1, 4'h1);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_after_clear: got %b expected 0", irq);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_before_second_match: got %b expected 0", irq);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      errors++; $display("FAIL irq_second_match: got %b expected 1", irq);
    end
    rd(A_COUNT, r);
    checks++;
    if (r !== 32'h0) begin
      errors++; $display("FAIL count_reloaded: got %h expected 0", r);
    end
  endtask

  task automatic test_prescaler;
    logic [31:0] r;
    logic [31:0] exp_v;
    do_reset();
    wr(A_CTRL, 32'h0301, 4'hF);
    for (int k = 0; k < 9; k++) begin
`ifdef TIMER_PRESCALER_EN
      exp_v = 32'(k / 4);
`else
      exp_v = 32'(k);
`endif
      rd(A_COUNT, r);
      checks++;
      if (r !== exp_v) begin
        errors++; $display("FAIL presc_count k=%0d: got %h expected %h", k, r, exp_v);
      end
    end
`ifdef TIMER_PRESCALER_EN
    exp_v = 32'h0301;
`else
    exp_v = 32'h0001;
`endif
    rd(A_CTRL, r);
    checks++;
    if (r !== exp_v) begin
      errors++; $display("FAIL presc_ctrl_readback: got %h expected %h", r, exp_v);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] r;
    logic [31:0] exp_tab [3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0};
    do_reset();
    wr(A_COUNT, 32'hFFFF_FFFE, 4'hF);
    wr(A_COMPARE, 32'h10, 4'hF);
    wr(A_CTRL, 32'h1, 4'hF);
    for (int k = 0; k < 3; k++) begin
      rd(A_COUNT, r);
      checks++;
      if (r !== exp_tab[k]) begin
        errors++; $display("FAIL wrap_count k=%0d: got %h expected %h", k, r, exp_tab[k]);
      end
    end
    rd(A_STATUS, r);
    checks++;
    if (r !== 32'h0) begin
      errors++; $display("FAIL wrap_no_match: got %h expected 0", r);
    end
    repeat (14) @(negedge clk);
    rd(A_STATUS, r);
    checks++;
    if (r !== 32'h0) begin
      errors++; $display("FAIL match_not_yet: got %h expected 0", r);
    end
    rd(A_COUNT, r);
    checks++;
    if (r !== 32'h11) begin
      errors++; $display("FAIL count_after_match: got %h expected 11", r);
    end
    rd(A_STATUS, r);
    checks++;
    if (r !== 32'h1 || irq !== 1'b0) begin
      errors++; $display("FAIL match_set_no_irq: got status=%h irq=%b expected 1/0", r, irq);
    end
  endtask

  task automatic test_simultaneous;
    logic [31:0] r;
    do_reset();
    wr(A_COMPARE, 32'd3, 4'hF);
    wr(A_CTRL, 32'h3, 4'hF);
    repeat (7) @(negedge clk);
    wr(A_STATUS, 32'h1, 4'hF);
    rd(A_STATUS, r);
    checks++;
    if (r !== 32'h1) begin
      errors++; $display("FAIL set_wins_over_clear: got %h expected 1", r);
    end
    do_reset();
    wr(A_COMPARE, 32'd2, 4'hF);
    wr(A_CTRL, 32'h1, 4'hF);
    repeat (2) @(negedge clk);
    wr(A_COUNT, 32'h100, 4'hF);
    rd(A_COUNT, r);
    checks++;
    if (r !== 32'h100) begin
      errors++; $display("FAIL count_write_during_tick: got %h expected 100", r);
    end
    rd(A_STATUS, r);
    checks++;
    if (r !== 32'h1) begin
      errors++; $display("FAIL match_uses_prewrite_count: got %h expected 1", r);
    end
    rd(A_COUNT, r);
    checks++;
    if (r !== 32'h102) begin
      errors++; $display("FAIL count_after_write: got %h expected 102", r);
    end
  endtask

  task automatic test_byte_enable;
    logic [31:0] r;
    logic [31:0] exp_v;
    do_reset();
    wr(A_COMPARE, 32'hAABB_CCDD, 4'b0010);
    rd(A_COMPARE, r);
    checks++;
    if (r !== 32'hFFFF_CCFF) begin
      errors++; $display("FAIL compare_be: got %h expected ffffccff", r);
    end
    wr(A_CTRL, 32'hFFFF_FFF8, 4'hF);
`ifdef TIMER_PRESCALER_EN
    exp_v = 32'h0000_FF00;
`else
    exp_v = 32'h0;
`endif
    rd(A_CTRL, r);
    checks++;
    if (r !== exp_v) begin
      errors++; $display("FAIL ctrl_reserved: got %h expected %h", r, exp_v);
    end
    wr(A_STATUS, 32'h0, 4'hF);
    rd(A_STATUS, r);
    checks++;
    if (r !== 32'h0) begin
      errors++; $display("FAIL status_write0: got %h expected 0", r);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] r;
    do_reset();
    req = 1'b1; en = 1'b1; we = 1'b0; addr = A_COMPARE; be = 4'h0;
    #2;
    rstn = 1'b0;
    @(negedge clk);
    req = 1'b0; en = 1'b0;
    checks++;
    if (rvalid !== 1'b0 || rdata !== 32'h0) begin
      errors++; $display("FAIL rvalid_in_reset: got rvalid=%b rdata=%h expected 0/0", rvalid, rdata);
    end
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (rvalid !== 1'b0) begin
        errors++; $display("FAIL rvalid_after_reset k=%0d: got %b expected 0", k, rvalid);
      end
    end
    rd(A_COMPARE, r);
    checks++;
    if (r !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL read_after_reset: got %h expected ffffffff", r);
    end
  endtask

  initial begin
    test_reset();
    test_autoreload();
    test_prescaler();
    test_wrap();
    test_simultaneous();
    test_byte_enable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
